param_data_memory: RTL

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

---
 rtl/param_data_memory.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/param_data_memory.sv
// Single-port word memory with a valid/ready request/response interface, byte-lane
// writes and a clear-on-reset INIT phase. Define DMEM_BOUNDS_CHECK_EN for range checking.
module param_data_memory #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 8,
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int BE_W     = DATA_W / 8;
  localparam bit USE_FILE = (INIT_FILE != "");

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]    idx;
  logic                oob;
  logic                accept;
  logic                init_last;
  logic [DATA_W-1:0]   be_mask;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_wmask;
  logic                unused_addr_hi;

  assign idx            = req_addr[IDX_W-1:0];
  assign unused_addr_hi = ^(req_addr >> IDX_W);
`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = (req_addr >> IDX_W) != '0;
`else
  // Without range checking, high address bits are ignored and addresses alias.
  assign oob = 1'b0;
`endif

  assign accept    = req_valid && req_ready;
  assign init_last = USE_FILE || (init_cnt_q == IDX_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_last) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  // Outputs: a stalled response blocks new requests
  always_comb begin
    busy      = (state_q == ST_INIT);
    req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  end

  always_comb begin
    for (int i = 0; i < BE_W; i++) be_mask[8*i +: 8] = {8{req_be[i]}};
  end

  // INIT clearing and request writes share the single write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = req_wdata;
    mem_wmask = be_mask;
    if (state_q == ST_INIT) begin
      mem_we    = !USE_FILE;
      mem_waddr = init_cnt_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else if (accept && req_we && !oob) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = oob;
      rsp_rdata_d = (req_we || oob) ? '0 : mem[idx];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
